// File: rtl/if_id_issue_buffer_pkg.sv
// Shared constants for the IF/ID issue buffer: NOP encoding, stall/flush bit map.
package if_id_issue_buffer_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int unsigned STALL_W     = 5;
  localparam int unsigned FLUSH_W     = 4;
  localparam int unsigned STALL_FETCH = 0;
  localparam int unsigned STALL_IFID  = 1;
  localparam int unsigned FLUSH_IFID  = 0;

  localparam logic [STALL_W-1:0] STALL_WFI = 5'b11111;

  // Decode-side demand: 0 when IF/ID stalls, 1 when only slot 0 issued, else 2.
  function automatic logic [1:0] popRequest(input logic stallIfid, input logic issueOne);
    logic [1:0] req;
    req = 2'd2;
    if (stallIfid) begin
      req = 2'd0;
    end else if (issueOne) begin
      req = 2'd1;
    end
    return req;
  endfunction

endpackage

// File: rtl/if_id_issue_buffer_issue_queue_ram.sv
// Entry storage for the issue buffer: two write ports, two combinational read ports, no reset.
module issue_queue_ram #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     wrEn,
  input  logic [$clog2(DEPTH)-1:0] wrAddr0,
  input  logic [$clog2(DEPTH)-1:0] wrAddr1,
  input  logic [WIDTH-1:0]         wrData0,
  input  logic [WIDTH-1:0]         wrData1,
  input  logic [$clog2(DEPTH)-1:0] rdAddr0,
  input  logic [$clog2(DEPTH)-1:0] rdAddr1,
  output logic [WIDTH-1:0]         rdData0,
  output logic [WIDTH-1:0]         rdData1
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Both halves of a packet land together; the addresses are always adjacent.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrAddr0] <= wrData0;
      mem[wrAddr1] <= wrData1;
    end
  end

  assign rdData0 = mem[rdAddr0];
  assign rdData1 = mem[rdAddr1];

endmodule

// File: rtl/if_id_issue_buffer.sv
// Dual-issue IF/ID buffer: circular queue of {pc, instr} fed two entries per fetch packet,
// drained 0/1/2 entries per cycle by decode.
module if_id_issue_buffer
  import if_id_issue_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned XLEN  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   Fetch_Valid,
  input  logic [2*XLEN-1:0]      Fetch_Instr,
  input  logic [XLEN-1:0]        Fetch_Pc,
  output logic                   Fetch_Ready,
  input  logic [STALL_W-1:0]     Ctrl_Stall,
  input  logic [FLUSH_W-1:0]     Flush,
  input  logic                   issue_select,
  output logic                   Id_Valid_0,
  output logic                   Id_Valid_1,
  output logic [XLEN-1:0]        Id_Instr_0,
  output logic [XLEN-1:0]        Id_Instr_1,
  output logic [XLEN-1:0]        Id_Pc_0,
  output logic [XLEN-1:0]        Id_Pc_1,
  output logic [$clog2(DEPTH):0] Buf_Count
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam int unsigned ENTRY_W = 2 * XLEN;

  logic [PTR_W-1:0]   head, headNext;
  logic [PTR_W-1:0]   tail, tailNext;
  logic [CNT_W-1:0]   count, countNext;
  logic               wfi;
  logic               flushIfid;
  logic               pushEn;
  logic [1:0]         popReq;
  logic [1:0]         popCnt;
  logic [ENTRY_W-1:0] wrData0, wrData1;
  logic [ENTRY_W-1:0] rdData0, rdData1;
  logic               unusedFlush;

  assign unusedFlush = ^Flush[FLUSH_W-1:1];

  assign wfi       = (Ctrl_Stall == STALL_WFI);
  assign flushIfid = Flush[FLUSH_IFID];

  // Readiness looks only at current occupancy so fetch never waits on decode's pop.
  assign Fetch_Ready = (count <= CNT_W'(DEPTH - 2)) && !Ctrl_Stall[STALL_FETCH];
  assign pushEn      = Fetch_Valid && Fetch_Ready && !flushIfid && !wfi;

  // Pop demand clamped to what is actually buffered.
  always_comb begin
    popReq = popRequest(Ctrl_Stall[STALL_IFID], issue_select);
    popCnt = popReq;
    if (CNT_W'(popReq) > count) begin
      popCnt = count[1:0];
    end
  end

  // Pointer/count update; flush wins over everything, WFI freezes.
  always_comb begin
    headNext  = head;
    tailNext  = tail;
    countNext = count;
    if (flushIfid) begin
      headNext  = '0;
      tailNext  = '0;
      countNext = '0;
    end else if (!wfi) begin
      headNext  = head + PTR_W'(popCnt);
      tailNext  = tail + (pushEn ? PTR_W'(2) : PTR_W'(0));
      countNext = count + (pushEn ? CNT_W'(2) : CNT_W'(0)) - CNT_W'(popCnt);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= headNext;
      tail  <= tailNext;
      count <= countNext;
    end
  end

  assign wrData0 = {Fetch_Pc, Fetch_Instr[XLEN-1:0]};
  assign wrData1 = {Fetch_Pc + XLEN'(4), Fetch_Instr[2*XLEN-1:XLEN]};

  issue_queue_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clk     (clk),
    .wrEn    (pushEn),
    .wrAddr0 (tail),
    .wrAddr1 (tail + PTR_W'(1)),
    .wrData0 (wrData0),
    .wrData1 (wrData1),
    .rdAddr0 (head),
    .rdAddr1 (head + PTR_W'(1)),
    .rdData0 (rdData0),
    .rdData1 (rdData1)
  );

  // Empty decode slots present a NOP at PC 0.
  assign Id_Valid_0 = (count != CNT_W'(0));
  assign Id_Valid_1 = (count >= CNT_W'(2));
  assign Id_Instr_0 = Id_Valid_0 ? rdData0[XLEN-1:0]       : XLEN'(NOP_INSTR);
  assign Id_Pc_0    = Id_Valid_0 ? rdData0[ENTRY_W-1:XLEN] : XLEN'(0);
  assign Id_Instr_1 = Id_Valid_1 ? rdData1[XLEN-1:0]       : XLEN'(NOP_INSTR);
  assign Id_Pc_1    = Id_Valid_1 ? rdData1[ENTRY_W-1:XLEN] : XLEN'(0);
  assign Buf_Count  = count;

endmodule

// File: tb/tb_if_id_issue_buffer.sv
// Scoreboard bench for if_id_issue_buffer: driver queues expected entries, negedge monitor checks issue.
module tb_if_id_issue_buffer;

  localparam int          DEPTH = 8;
  localparam int          XLEN  = 32;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Fetch_Valid;
  logic [63:0] Fetch_Instr;
  logic [31:0] Fetch_Pc;
  logic        Fetch_Ready;
  logic [4:0]  Ctrl_Stall;
  logic [3:0]  Flush;
  logic        issue_select;
  logic        Id_Valid_0, Id_Valid_1;
  logic [31:0] Id_Instr_0, Id_Instr_1, Id_Pc_0, Id_Pc_1;
  logic [3:0]  Buf_Count;

  ent_t        sbQ[$];
  int          mCount;
  int          tests;
  int          fails;
  bit          armed;
  bit          seqMode;
  logic [31:0] lastPc;
  int          seqIssued;

  always #5 clk = ~clk;

  if_id_issue_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Fetch_Valid  (Fetch_Valid),
    .Fetch_Instr  (Fetch_Instr),
    .Fetch_Pc     (Fetch_Pc),
    .Fetch_Ready  (Fetch_Ready),
    .Ctrl_Stall   (Ctrl_Stall),
    .Flush        (Flush),
    .issue_select (issue_select),
    .Id_Valid_0   (Id_Valid_0),
    .Id_Valid_1   (Id_Valid_1),
    .Id_Instr_0   (Id_Instr_0),
    .Id_Instr_1   (Id_Instr_1),
    .Id_Pc_0      (Id_Pc_0),
    .Id_Pc_1      (Id_Pc_1),
    .Buf_Count    (Buf_Count)
  );

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] instrOf(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0000;
  endfunction

  // Drive one cycle of inputs, update the reference model, and advance past the edge.
  task automatic step(input bit fv, input logic [31:0] pc, input logic [31:0] i0,
                      input logic [31:0] i1, input logic [4:0] st, input logic [3:0] fl,
                      input bit sel, input bit rstv, output bit acc);
    int  nxt;
    int  pop;
    int  req;
    bit  ready;
    Fetch_Valid  = fv;
    Fetch_Pc     = pc;
    Fetch_Instr  = {i1, i0};
    Ctrl_Stall   = st;
    Flush        = fl;
    issue_select = sel;
    rst_n        = rstv;
    acc          = 1'b0;
    ready        = (mCount <= DEPTH - 2) && !st[0];
    if (!rstv || fl[0]) begin
      nxt = 0;
      sbQ.delete();
    end else if (st == 5'h1f) begin
      nxt = mCount;
    end else begin
      acc = fv && ready;
      req = st[1] ? 0 : (sel ? 1 : 2);
      pop = (req > mCount) ? mCount : req;
      if (acc) begin
        sbQ.push_back('{pc: pc, instr: i0});
        sbQ.push_back('{pc: pc + 32'd4, instr: i1});
      end
      nxt = mCount + (acc ? 2 : 0) - pop;
    end
    @(posedge clk);
    #1;
    mCount = nxt;
  endtask

  task automatic pkt(input logic [31:0] pc, input logic [4:0] st);
    bit acc;
    step(1'b1, pc, instrOf(pc), instrOf(pc + 32'd4), st, 4'h0, 1'b0, 1'b1, acc);
  endtask

  task automatic idle(input logic [4:0] st, input bit sel);
    bit acc;
    step(1'b0, 32'h0, 32'h0, 32'h0, st, 4'h0, sel, 1'b1, acc);
  endtask

  // Monitor: checks status against the model and compares every entry decode consumes.
  always @(negedge clk) begin
    int   n;
    ent_t e;
    if (armed && rst_n === 1'b1) begin
      check("buf_count", 64'(Buf_Count), 64'(mCount));
      check("fetch_ready", 64'(Fetch_Ready), 64'((mCount <= DEPTH - 2) && !Ctrl_Stall[0]));
      check("id_valid_0", 64'(Id_Valid_0), 64'(mCount >= 1));
      check("id_valid_1", 64'(Id_Valid_1), 64'(mCount >= 2));
      if (mCount < 1) begin
        check("nop_instr_0", 64'(Id_Instr_0), 64'(NOP));
        check("nop_pc_0", 64'(Id_Pc_0), 64'h0);
      end
      if (mCount < 2) begin
        check("nop_instr_1", 64'(Id_Instr_1), 64'(NOP));
        check("nop_pc_1", 64'(Id_Pc_1), 64'h0);
      end
      n = 0;
      if (!Flush[0] && Ctrl_Stall != 5'h1f && !Ctrl_Stall[1]) n = issue_select ? 1 : 2;
      if (n > mCount) n = mCount;
      for (int i = 0; i < n; i++) begin
        if (sbQ.size() == 0) begin
          check("scoreboard_underflow", 64'h1, 64'h0);
        end else begin
          e = sbQ.pop_front();
          if (i == 0) begin
            check("slot0_pc", 64'(Id_Pc_0), 64'(e.pc));
            check("slot0_instr", 64'(Id_Instr_0), 64'(e.instr));
          end else begin
            check("slot1_pc", 64'(Id_Pc_1), 64'(e.pc));
            check("slot1_instr", 64'(Id_Instr_1), 64'(e.instr));
          end
          if (seqMode) begin
            check("seq_pc", (i == 0) ? 64'(Id_Pc_0) : 64'(Id_Pc_1), 64'(lastPc + 32'd4));
            lastPc    = lastPc + 32'd4;
            seqIssued = seqIssued + 1;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          acc;
    int          pushed;
    logic [31:0] nextPc;
    tests = 0; fails = 0; armed = 1'b0; seqMode = 1'b0; mCount = 0; seqIssued = 0;
    rst_n = 1'b0; Fetch_Valid = 1'b0; Fetch_Instr = '0; Fetch_Pc = '0;
    Ctrl_Stall = '0; Flush = '0; issue_select = 1'b0;
    @(posedge clk);
    #1;
    step(1'b0, 32'h0, 32'h0, 32'h0, 5'h00, 4'h0, 1'b0, 1'b0, acc);
    step(1'b0, 32'h0, 32'h0, 32'h0, 5'h00, 4'h0, 1'b0, 1'b0, acc);
    armed = 1'b1;
    check("reset_count", 64'(Buf_Count), 64'h0);
    check("reset_instr_0", 64'(Id_Instr_0), 64'(NOP));

    // First packet visible one cycle after the push edge.
    step(1'b1, 32'h100, 32'hAAA, 32'hBBB, 5'b00010, 4'h0, 1'b0, 1'b1, acc);
    check("push_valid_1", 64'(Id_Valid_1), 64'h1);
    check("push_pc_0", 64'(Id_Pc_0), 64'h100);
    check("push_pc_1", 64'(Id_Pc_1), 64'h104);
    check("push_instr_1", 64'(Id_Instr_1), 64'hBBB);

    // Single issue: slot 1 replays into slot 0.
    idle(5'b00000, 1'b1);
    check("single_count", 64'(Buf_Count), 64'h1);
    check("single_pc_0", 64'(Id_Pc_0), 64'h104);
    check("single_valid_1", 64'(Id_Valid_1), 64'h0);
    idle(5'b00000, 1'b0);

    // Fill with decode stalled, then drain two per cycle.
    for (int k = 0; k < 4; k++) pkt(32'h200 + 32'(8 * k), 5'b00010);
    check("full_count", 64'(Buf_Count), 64'h8);
    check("full_ready", 64'(Fetch_Ready), 64'h0);
    pkt(32'h2F0, 5'b00010);
    check("full_no_push", 64'(Buf_Count), 64'h8);
    idle(5'b00000, 1'b0);
    check("drain_6", 64'(Buf_Count), 64'h6);
    idle(5'b00000, 1'b0);
    check("drain_4", 64'(Buf_Count), 64'h4);
    idle(5'b00000, 1'b0);
    idle(5'b00000, 1'b0);
    check("drain_0", 64'(Buf_Count), 64'h0);

    // Reset in the middle of operation drops buffered entries.
    pkt(32'h280, 5'b00010);
    step(1'b0, 32'h0, 32'h0, 32'h0, 5'h00, 4'h0, 1'b0, 1'b0, acc);
    check("midreset_count", 64'(Buf_Count), 64'h0);
    check("midreset_valid_0", 64'(Id_Valid_0), 64'h0);
    idle(5'b00000, 1'b0);

    // Flush with a packet offered at count 5.
    for (int k = 0; k < 3; k++) pkt(32'h300 + 32'(8 * k), 5'b00010);
    idle(5'b00000, 1'b1);
    check("preflush_count", 64'(Buf_Count), 64'h5);
    step(1'b1, 32'h400, instrOf(32'h400), instrOf(32'h404), 5'b00000, 4'b0001, 1'b0, 1'b1, acc);
    check("flush_count", 64'(Buf_Count), 64'h0);
    check("flush_valid_0", 64'(Id_Valid_0), 64'h0);
    check("flush_instr_0", 64'(Id_Instr_0), 64'(NOP));
    idle(5'b00000, 1'b0);
    check("flush_dropped", 64'(Buf_Count), 64'h0);

    // WFI freezes everything even with fetch offering.
    pkt(32'h500, 5'b00010);
    pkt(32'h508, 5'b00010);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 32'h600, instrOf(32'h600), instrOf(32'h604), 5'h1f, 4'h0, 1'b0, 1'b1, acc);
      check("wfi_count", 64'(Buf_Count), 64'h4);
      check("wfi_pc_0", 64'(Id_Pc_0), 64'h500);
      check("wfi_pc_1", 64'(Id_Pc_1), 64'h504);
      check("wfi_instr_0", 64'(Id_Instr_0), 64'(instrOf(32'h500)));
    end
    idle(5'b00000, 1'b0);
    idle(5'b00000, 1'b0);
    check("wfi_drained", 64'(Buf_Count), 64'h0);

    // 20 packets under random stalls, wrapping the pointers several times.
    seqMode = 1'b1;
    lastPc  = 32'h1000 - 32'd4;
    pushed  = 0;
    nextPc  = 32'h1000;
    for (int it = 0; it < 400 && pushed < 20; it++) begin
      step($urandom_range(0, 3) != 0, nextPc, instrOf(nextPc), instrOf(nextPc + 32'd4),
           {3'b000, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3}, 4'h0,
           1'($urandom_range(0, 1)), 1'b1, acc);
      if (acc) begin
        pushed = pushed + 1;
        nextPc = nextPc + 32'd8;
      end
    end
    for (int it = 0; it < 50 && mCount > 0; it++) idle(5'b00000, 1'b0);
    check("random_pushed", 64'(pushed), 64'd20);
    check("random_issued", 64'(seqIssued), 64'd40);
    check("random_sb_empty", 64'(sbQ.size()), 64'h0);
    seqMode = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
